gpio_bank_controller: RTL and testbench

Parametrised successor to the 8-bit GPIO controller. Sits behind the IO manager on the same IOOut/IOIn request/acknowledge interface and serves GPIOWIDTH pins, organised as 8-bit banks. Adds per-bank set/clear/toggle operations and input synchronisation. Adds rising- and falling-edge detection with sticky event registers and read-and-clear.

---
 rtl/gpio_bank_pkg.sv | 32 +++
 rtl/gpio_edge_detect.sv | 58 +++++
 rtl/gpio_bank_controller.sv | 167 ++++++++++++++++
 tb/tb_gpio_bank_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared opcode, command-field and state definitions for the banked GPIO controller.
package gpio_bank_pkg;

  typedef enum logic [3:0] {
    OP_READ_IN        = 4'h0,
    OP_WRITE_OUT      = 4'h1,
    OP_WRITE_OE       = 4'h2,
    OP_SET_OUT        = 4'h3,
    OP_CLR_OUT        = 4'h4,
    OP_TGL_OUT        = 4'h5,
    OP_READ_OUT       = 4'h6,
    OP_READ_OE        = 4'h7,
    OP_WRITE_RISEMASK = 4'h8,
    OP_WRITE_FALLMASK = 4'h9,
    OP_READCLR_EVENTS = 4'hA
  } gpio_op_e;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int BANK_MSB = 11;
  localparam int BANK_LSB = 8;
  localparam int VAL_MSB  = 7;
  localparam int VAL_LSB  = 0;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} gpio_state_e;

  function automatic logic is_read_op(input logic [3:0] op);
    return (op == OP_READ_IN) || (op == OP_READ_OUT) ||
           (op == OP_READ_OE) || (op == OP_READCLR_EVENTS);
  endfunction

endpackage

// File: rtl/gpio_edge_detect.sv
// Input synchroniser, edge detector and sticky event register for the GPIO pins.
module gpio_edge_detect #(
  parameter int GPIOWIDTH  = 16,
  parameter int SYNCSTAGES = 2
) (
  input  logic                 clk,
  input  logic                 sync_rst,
  input  logic                 clk_en,
  input  logic [GPIOWIDTH-1:0] din_i,
  input  logic [GPIOWIDTH-1:0] rise_mask_i,
  input  logic [GPIOWIDTH-1:0] fall_mask_i,
  input  logic [GPIOWIDTH-1:0] clr_i,
  output logic [GPIOWIDTH-1:0] sync_o,
  output logic [GPIOWIDTH-1:0] events_o
);

  localparam int CW = $clog2(SYNCSTAGES + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(SYNCSTAGES + 1);

  logic [GPIOWIDTH-1:0] sync_q [SYNCSTAGES];
  logic [GPIOWIDTH-1:0] prev_q;
  logic [GPIOWIDTH-1:0] events_q;
  logic [GPIOWIDTH-1:0] events_d;
  logic [GPIOWIDTH-1:0] new_ev;
  logic [CW-1:0]        cnt_q;
  logic                 gate;

  assign sync_o   = sync_q[SYNCSTAGES-1];
  assign events_o = events_q;

  // Until the chain and prev have filled with real pin values, a reset-to-live
  // transition would look like an edge, so detection stays gated off.
  assign gate = (cnt_q == CNT_MAX);

  always_comb begin
    new_ev = '0;
    if (gate) begin
      new_ev = (sync_o & ~prev_q & rise_mask_i) | (~sync_o & prev_q & fall_mask_i);
    end
    events_d = (events_q & ~clr_i) | new_ev;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < SYNCSTAGES; i++) sync_q[i] <= '0;
      prev_q   <= '0;
      events_q <= '0;
      cnt_q    <= '0;
    end else if (clk_en) begin
      sync_q[0] <= din_i;
      for (int i = 1; i < SYNCSTAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q   <= sync_o;
      events_q <= events_d;
      if (!gate) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_bank_controller.sv
// Banked GPIO controller on the IOOut/IOIn request/acknowledge interface.
// Optional IRQ output enabled by defining GPIO_BANK_IRQ_EN.
module gpio_bank_controller
  import gpio_bank_pkg::*;
#(
  parameter int DATABITWIDTH = 16,
  parameter int GPIOWIDTH    = 16,
  parameter int SYNCSTAGES   = 2
) (
  input  logic                    clk,
  input  logic                    sync_rst,
  input  logic                    clk_en,
  input  logic                    IOOut_REQ,
  output logic                    IOOut_ACK,
  input  logic                    IOOut_ResponseRequested,
  input  logic [3:0]              IOOut_DestReg,
  input  logic [DATABITWIDTH-1:0] IOOut_Data,
  output logic                    IOIn_REQ,
  input  logic                    IOIn_ACK,
  output logic                    IOIn_RegResponseFlag,
  output logic                    IOIn_MemResponseFlag,
  output logic [3:0]              IOIn_DestReg,
  output logic [DATABITWIDTH-1:0] IOIn_Data,
  input  logic [GPIOWIDTH-1:0]    GPIO_DIn,
  output logic [GPIOWIDTH-1:0]    GPIO_DOut,
  output logic [GPIOWIDTH-1:0]    GPIO_DOutEn
`ifdef GPIO_BANK_IRQ_EN
  ,output logic                   IRQ
`endif
);

  localparam int BANKS = GPIOWIDTH / 8;

  gpio_state_e          state_q;
  logic [GPIOWIDTH-1:0] dout_q, dout_d;
  logic [GPIOWIDTH-1:0] douten_q, douten_d;
  logic [GPIOWIDTH-1:0] rise_q, rise_d;
  logic [GPIOWIDTH-1:0] fall_q, fall_d;
  logic [GPIOWIDTH-1:0] clr;
  logic [GPIOWIDTH-1:0] sync_pins;
  logic [GPIOWIDTH-1:0] events;
  logic [7:0]           resp_data_q, resp_val;
  logic [3:0]           dest_q;
  logic                 mem_q, reg_q;
  logic                 accept;
  logic [3:0]           op, bank;
  logic [7:0]           val, new_out;
  logic                 bank_ok;
  int                   idx;

  assign IOOut_ACK            = (state_q == IDLE) && clk_en && !sync_rst;
  assign accept               = IOOut_REQ && IOOut_ACK;
  assign IOIn_REQ             = (state_q == RESP);
  assign IOIn_Data            = {{(DATABITWIDTH-8){1'b0}}, resp_data_q};
  assign IOIn_DestReg         = dest_q;
  assign IOIn_MemResponseFlag = mem_q;
  assign IOIn_RegResponseFlag = reg_q;
  assign GPIO_DOut            = dout_q;
  assign GPIO_DOutEn          = douten_q;

  assign op   = IOOut_Data[OP_MSB:OP_LSB];
  assign bank = IOOut_Data[BANK_MSB:BANK_LSB];
  assign val  = IOOut_Data[VAL_MSB:VAL_LSB];

  gpio_edge_detect #(
    .GPIOWIDTH  (GPIOWIDTH),
    .SYNCSTAGES (SYNCSTAGES)
  ) u_edge (
    .clk         (clk),
    .sync_rst    (sync_rst),
    .clk_en      (clk_en),
    .din_i       (GPIO_DIn),
    .rise_mask_i (rise_q),
    .fall_mask_i (fall_q),
    .clr_i       (clr),
    .sync_o      (sync_pins),
    .events_o    (events)
  );

  // Out-of-range banks alias bank 0 for indexing only; bank_ok masks every effect.
  always_comb begin
    bank_ok  = (int'(bank) < BANKS);
    idx      = bank_ok ? int'(bank) : 0;
    dout_d   = dout_q;
    douten_d = douten_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    clr      = '0;

    case (op)
      OP_WRITE_OUT: new_out = val;
      OP_SET_OUT:   new_out = dout_q[idx*8 +: 8] | val;
      OP_CLR_OUT:   new_out = dout_q[idx*8 +: 8] & ~val;
      OP_TGL_OUT:   new_out = dout_q[idx*8 +: 8] ^ val;
      default:      new_out = dout_q[idx*8 +: 8];
    endcase

    case (op)
      OP_READ_IN:                               resp_val = sync_pins[idx*8 +: 8];
      OP_WRITE_OUT, OP_SET_OUT, OP_CLR_OUT,
      OP_TGL_OUT:                               resp_val = new_out;
      OP_WRITE_OE, OP_WRITE_RISEMASK,
      OP_WRITE_FALLMASK:                        resp_val = val;
      OP_READ_OUT:                              resp_val = dout_q[idx*8 +: 8];
      OP_READ_OE:                               resp_val = douten_q[idx*8 +: 8];
      OP_READCLR_EVENTS:                        resp_val = events[idx*8 +: 8];
      default:                                  resp_val = 8'h00;
    endcase
    if (!bank_ok) resp_val = 8'h00;

    if (accept && bank_ok) begin
      case (op)
        OP_WRITE_OUT, OP_SET_OUT, OP_CLR_OUT,
        OP_TGL_OUT:        dout_d[idx*8 +: 8]   = new_out;
        OP_WRITE_OE:       douten_d[idx*8 +: 8] = val;
        OP_WRITE_RISEMASK: rise_d[idx*8 +: 8]   = val;
        OP_WRITE_FALLMASK: fall_d[idx*8 +: 8]   = val;
        OP_READCLR_EVENTS: clr[idx*8 +: 8]      = events[idx*8 +: 8];
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q     <= IDLE;
      dout_q      <= '0;
      douten_q    <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      resp_data_q <= '0;
      dest_q      <= '0;
      mem_q       <= 1'b0;
      reg_q       <= 1'b0;
    end else if (clk_en) begin
      dout_q   <= dout_d;
      douten_q <= douten_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      case (state_q)
        IDLE: begin
          if (accept && IOOut_ResponseRequested) begin
            state_q     <= RESP;
            resp_data_q <= resp_val;
            dest_q      <= IOOut_DestReg;
            mem_q       <= is_read_op(op);
            reg_q       <= 1'b1;
          end
        end
        RESP: begin
          if (IOIn_ACK) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef GPIO_BANK_IRQ_EN
  logic irq_q;
  assign IRQ = irq_q;
  always_ff @(posedge clk) begin
    if (sync_rst)    irq_q <= 1'b0;
    else if (clk_en) irq_q <= |events;
  end
`endif

endmodule

// File: tb/tb_gpio_bank_controller.sv
// Directed bench for gpio_bank_controller: register ops, reads, edge events, handshake and reset.
module tb_gpio_bank_controller;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        clk_en;
  logic        IOOut_REQ;
  logic        IOOut_ACK;
  logic        IOOut_ResponseRequested;
  logic [3:0]  IOOut_DestReg;
  logic [15:0] IOOut_Data;
  logic        IOIn_REQ;
  logic        IOIn_ACK;
  logic        IOIn_RegResponseFlag;
  logic        IOIn_MemResponseFlag;
  logic [3:0]  IOIn_DestReg;
  logic [15:0] IOIn_Data;
  logic [15:0] GPIO_DIn;
  logic [15:0] GPIO_DOut;
  logic [15:0] GPIO_DOutEn;
`ifdef GPIO_BANK_IRQ_EN
  logic        IRQ;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  gpio_bank_controller dut (
    .clk                     (clk),
    .sync_rst                (sync_rst),
    .clk_en                  (clk_en),
    .IOOut_REQ               (IOOut_REQ),
    .IOOut_ACK               (IOOut_ACK),
    .IOOut_ResponseRequested (IOOut_ResponseRequested),
    .IOOut_DestReg           (IOOut_DestReg),
    .IOOut_Data              (IOOut_Data),
    .IOIn_REQ                (IOIn_REQ),
    .IOIn_ACK                (IOIn_ACK),
    .IOIn_RegResponseFlag    (IOIn_RegResponseFlag),
    .IOIn_MemResponseFlag    (IOIn_MemResponseFlag),
    .IOIn_DestReg            (IOIn_DestReg),
    .IOIn_Data               (IOIn_Data),
    .GPIO_DIn                (GPIO_DIn),
    .GPIO_DOut               (GPIO_DOut),
    .GPIO_DOutEn             (GPIO_DOutEn)
`ifdef GPIO_BANK_IRQ_EN
    ,.IRQ                    (IRQ)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Valid/ready: a command transfers on the rising edge where IOOut_REQ and
  // IOOut_ACK are both high; a response transfers where IOIn_REQ and IOIn_ACK are.
  task automatic do_cmd(input logic [3:0] op, input logic [3:0] bank, input logic [7:0] val,
                        input logic resp, input logic [3:0] tag,
                        output logic [7:0] rdata, output logic rmem);
    int n = 0;
    IOOut_REQ = 1'b1;
    IOOut_Data = {op, bank, val};
    IOOut_ResponseRequested = resp;
    IOOut_DestReg = tag;
    while (!IOOut_ACK && n < 20) begin
      tick(1);
      n++;
    end
    check("cmd_ack", IOOut_ACK, 1);
    tick(1);
    IOOut_REQ = 1'b0;
    IOOut_ResponseRequested = 1'b0;
    rdata = 8'h00;
    rmem = 1'b0;
    if (resp) begin
      check("resp_req", IOIn_REQ, 1);
      check("resp_tag", IOIn_DestReg, tag);
      check("resp_regflag", IOIn_RegResponseFlag, 1);
      check("resp_zext", IOIn_Data[15:8], 0);
      rdata = IOIn_Data[7:0];
      rmem = IOIn_MemResponseFlag;
      IOIn_ACK = 1'b1;
      tick(1);
      IOIn_ACK = 1'b0;
      check("resp_drop", IOIn_REQ, 0);
    end
  endtask

  logic [7:0] rd;
  logic       rm;

  initial begin
    sync_rst = 1'b1;
    clk_en = 1'b1;
    IOOut_REQ = 1'b0;
    IOOut_ResponseRequested = 1'b0;
    IOOut_DestReg = 4'h0;
    IOOut_Data = 16'h0000;
    IOIn_ACK = 1'b0;
    GPIO_DIn = 16'h0000;
    tick(3);
    check("rst_ack", IOOut_ACK, 0);
    check("rst_req", IOIn_REQ, 0);
    check("rst_dout", GPIO_DOut, 16'h0000);
    check("rst_douten", GPIO_DOutEn, 16'h0000);
    sync_rst = 1'b0;
    tick(5);
    check("idle_ack", IOOut_ACK, 1);
    clk_en = 1'b0;
    #1;
    check("clken_ack", IOOut_ACK, 0);
    clk_en = 1'b1;
    tick(1);

    // 1: bank1 output enable and data
    do_cmd(4'h2, 4'h1, 8'hFF, 1'b0, 4'h0, rd, rm);
    check("t1_douten", GPIO_DOutEn, 16'hFF00);
    do_cmd(4'h1, 4'h1, 8'hA5, 1'b0, 4'h0, rd, rm);
    check("t1_dout", GPIO_DOut, 16'hA500);

    // 2: write/set/clr/tgl on bank0 with responses
    do_cmd(4'h1, 4'h0, 8'h0F, 1'b1, 4'h3, rd, rm);
    check("t2_wr", rd, 8'h0F);
    do_cmd(4'h3, 4'h0, 8'hF0, 1'b1, 4'h5, rd, rm);
    check("t2_set", rd, 8'hFF);
    check("t2_set_mem", rm, 0);
    do_cmd(4'h4, 4'h0, 8'h03, 1'b1, 4'h9, rd, rm);
    check("t2_clr", rd, 8'hFC);
    do_cmd(4'h5, 4'h0, 8'hFF, 1'b1, 4'hC, rd, rm);
    check("t2_tgl", rd, 8'h03);
    check("t2_tgl_mem", rm, 0);
    check("t2_dout", GPIO_DOut, 16'hA503);

    // 3: synchronised input reads and readbacks
    GPIO_DIn = 16'h1234;
    tick(4);
    do_cmd(4'h0, 4'h0, 8'h00, 1'b1, 4'h1, rd, rm);
    check("t3_in0", rd, 8'h34);
    check("t3_in0_mem", rm, 1);
    do_cmd(4'h0, 4'h1, 8'h00, 1'b1, 4'h2, rd, rm);
    check("t3_in1", rd, 8'h12);
    do_cmd(4'h0, 4'h5, 8'h00, 1'b1, 4'h4, rd, rm);
    check("t3_in5", rd, 8'h00);
    do_cmd(4'h6, 4'h1, 8'h00, 1'b1, 4'h6, rd, rm);
    check("t3_rdout", rd, 8'hA5);
    do_cmd(4'h7, 4'h0, 8'h00, 1'b1, 4'h8, rd, rm);
    check("t3_rdoe", rd, 8'h00);
    do_cmd(4'h1, 4'h5, 8'h77, 1'b1, 4'hA, rd, rm);
    check("t3_oob_wr", rd, 8'h00);
    check("t3_oob_dout", GPIO_DOut, 16'hA503);

    // 4: rise/fall events with read-and-clear
    GPIO_DIn = 16'h1236;
    tick(5);
    do_cmd(4'h8, 4'h0, 8'h01, 1'b1, 4'hB, rd, rm);
    check("t4_rmask", rd, 8'h01);
    do_cmd(4'h9, 4'h0, 8'h02, 1'b0, 4'h0, rd, rm);
    GPIO_DIn = 16'h1237;
    tick(4);
    GPIO_DIn = 16'h1235;
    tick(4);
    GPIO_DIn = 16'h1234;
    tick(4);
    do_cmd(4'hA, 4'h0, 8'h00, 1'b1, 4'hD, rd, rm);
    check("t4_ev", rd, 8'h03);
    check("t4_ev_mem", rm, 1);
    do_cmd(4'hA, 4'h0, 8'h00, 1'b1, 4'hD, rd, rm);
    check("t4_ev_clr", rd, 8'h00);

    // 5: stalled response, then reset mid-response
    IOOut_REQ = 1'b1;
    IOOut_Data = 16'h6100;
    IOOut_ResponseRequested = 1'b1;
    IOOut_DestReg = 4'h7;
    tick(1);
    IOOut_REQ = 1'b0;
    IOOut_ResponseRequested = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_req_hold", IOIn_REQ, 1);
      check("t5_data_hold", IOIn_Data, 16'h00A5);
      check("t5_ack_low", IOOut_ACK, 0);
      tick(1);
    end
    sync_rst = 1'b1;
    tick(1);
    check("t5_rst_req", IOIn_REQ, 0);
    check("t5_rst_data", IOIn_Data, 16'h0000);
    check("t5_rst_tag", IOIn_DestReg, 0);
    check("t5_rst_flags", {IOIn_RegResponseFlag, IOIn_MemResponseFlag}, 0);
    check("t5_rst_dout", GPIO_DOut, 16'h0000);
    check("t5_rst_douten", GPIO_DOutEn, 16'h0000);
    sync_rst = 1'b0;
    tick(6);
    do_cmd(4'hA, 4'h0, 8'h00, 1'b1, 4'h2, rd, rm);
    check("t5_rst_ev", rd, 8'h00);

    // 6: new event coinciding with read-and-clear
    do_cmd(4'h8, 4'h0, 8'h01, 1'b0, 4'h0, rd, rm);
    tick(3);
    GPIO_DIn = 16'h1235;
    tick(2);
    do_cmd(4'hA, 4'h0, 8'h00, 1'b1, 4'h3, rd, rm);
    check("t6_first", rd, 8'h00);
`ifdef GPIO_BANK_IRQ_EN
    check("t6_irq_between", IRQ, 1);
`endif
    do_cmd(4'hA, 4'h0, 8'h00, 1'b1, 4'h3, rd, rm);
    check("t6_second", rd, 8'h01);
    tick(2);
`ifdef GPIO_BANK_IRQ_EN
    check("t6_irq_drop", IRQ, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
